// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: register scoreboard, stall/flush FSM, stall perf counter and timeout.
// Optional macro HAZARD_CTRL_BYPASS_EN: same-cycle writeback hides the busy bit from the hazard check.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_MAX    = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_regwrite,
  input  logic             ex_branch_taken,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  output logic             issue,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             flush,
  output logic [31:0]      busy_vec,
  output logic [CNT_W-1:0] stall_count,
  output logic             stall_timeout
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int         CONSEC_W     = $clog2(STALL_MAX + 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [1:0]          state_q, state_d;
  logic [2:0]          flush_cnt_q, flush_cnt_d;
  logic [31:0]         busy_q, busy_d;
  logic [CNT_W-1:0]    stall_count_q, stall_count_d;
  logic [CONSEC_W-1:0] consec_q, consec_d;
  logic                timeout_q, timeout_d;

  logic [1:0]  cur_state;
  logic [31:0] cur_busy;
  logic [31:0] hz_busy;
  logic [31:0] wb_mask;
  logic [31:0] set_mask;
  logic        hazard;
  logic        stall;

  // While reset is asserted the outputs already behave as if the registers held their reset values.
  assign cur_state = reset ? state_q : ST_RUN;
  assign cur_busy  = reset ? busy_q : 32'd0;
  assign wb_mask   = wb_valid ? (32'd1 << wb_rd) : 32'd0;

`ifdef HAZARD_CTRL_BYPASS_EN
  assign hz_busy = cur_busy & ~wb_mask;
`else
  assign hz_busy = cur_busy;
`endif

  assign hazard = id_valid &&
                  ((id_use_rs1  && (id_rs1 != 5'd0) && hz_busy[id_rs1]) ||
                   (id_use_rs2  && (id_rs2 != 5'd0) && hz_busy[id_rs2]) ||
                   (id_regwrite && (id_rd  != 5'd0) && hz_busy[id_rd]));

  assign flush        = ex_branch_taken || (cur_state == ST_FLUSH);
  assign issue        = id_valid && !hazard && !flush;
  assign stall        = hazard && !flush;
  assign pc_write     = !stall;
  assign if_id_write  = !stall;
  assign id_ex_bubble = !issue;

  assign busy_vec      = busy_q;
  assign stall_count   = stall_count_q;
  assign stall_timeout = timeout_q;

  assign set_mask = (issue && id_regwrite) ? (32'd1 << id_rd) : 32'd0;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block can infer a latch.
    state_d     = cur_state;
    flush_cnt_d = flush_cnt_q;
    if (ex_branch_taken) begin
      state_d     = ST_FLUSH;
      flush_cnt_d = FLUSH_RELOAD;
    end else begin
      case (cur_state)
        ST_RUN:   if (hazard) state_d = ST_STALL;
        ST_STALL: if (!hazard) state_d = ST_RUN;
        ST_FLUSH: begin
          if (flush_cnt_q == 3'd0) state_d = ST_RUN;
          else                     flush_cnt_d = flush_cnt_q - 3'd1;
        end
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    // Set is applied after clear so an issuing writer wins over a same-index writeback.
    busy_d = ((busy_q & ~wb_mask) | set_mask) & ~32'd1;

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) stall_count_d = stall_count_q + CNT_W'(1);

    consec_d = '0;
    if (stall) begin
      consec_d = (consec_q == CONSEC_W'(STALL_MAX)) ? consec_q : consec_q + CONSEC_W'(1);
    end

    timeout_d = timeout_q || (consec_d == CONSEC_W'(STALL_MAX));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_RUN;
      flush_cnt_q   <= 3'd0;
      busy_q        <= 32'd0;
      stall_count_q <= '0;
      consec_q      <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      busy_q        <= busy_d;
      stall_count_q <= stall_count_d;
      consec_q      <= consec_d;
      timeout_q     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver pushes model predictions per cycle, a monitor pops and compares.
module tb_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int STALL_MAX    = 15;
  localparam int CNT_W        = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             id_valid, id_use_rs1, id_use_rs2, id_regwrite;
  logic [4:0]       id_rs1, id_rs2, id_rd, wb_rd;
  logic             ex_branch_taken, wb_valid;
  logic             issue, pc_write, if_id_write, id_ex_bubble, flush, stall_timeout;
  logic [31:0]      busy_vec;
  logic [CNT_W-1:0] stall_count;

  hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .STALL_MAX(STALL_MAX), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_regwrite(id_regwrite),
    .ex_branch_taken(ex_branch_taken), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue(issue), .pc_write(pc_write), .if_id_write(if_id_write),
    .id_ex_bubble(id_ex_bubble), .flush(flush),
    .busy_vec(busy_vec), .stall_count(stall_count), .stall_timeout(stall_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       rst_n, valid, use1, use2, regw, br, wbv;
    bit [4:0] rs1, rs2, rd, wbrd;
  } stim_t;

  typedef struct {
    bit        issue, pcw, ifw, bubble, flush, timeout;
    bit [31:0] busy;
    longint    scount;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Reference model: busy registers as a bit array, flush as "cycles still to flush", plain counters.
  bit     m_busy[32];
  int     m_flush_left;
  longint m_scount;
  int     m_run_len;
  bit     m_timeout;
  stim_t  prev;
  bit     m_hazard, m_flush, m_issue;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic bit blocked(input stim_t s, input bit [4:0] r);
    bit b;
    b = s.rst_n && m_busy[r];
`ifdef HAZARD_CTRL_BYPASS_EN
    if (s.wbv && s.wbrd == r) b = 0;
`endif
    return (r != 0) && b;
  endfunction

  function automatic void predict(input stim_t s);
    m_hazard = s.valid && ((s.use1 && blocked(s, s.rs1)) ||
                           (s.use2 && blocked(s, s.rs2)) ||
                           (s.regw && blocked(s, s.rd)));
    m_flush  = s.br || (s.rst_n && m_flush_left > 0);
    m_issue  = s.valid && !m_hazard && !m_flush;
  endfunction

  function automatic void advance(input stim_t s);
    bit stalled;
    predict(s);
    stalled = m_hazard && !m_flush;
    if (!s.rst_n) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_flush_left = 0; m_scount = 0; m_run_len = 0; m_timeout = 0;
      return;
    end
    if (s.wbv) m_busy[s.wbrd] = 0;
    if (m_issue && s.regw) m_busy[s.rd] = 1;
    m_busy[0] = 0;
    if (s.br)                  m_flush_left = FLUSH_CYCLES;
    else if (m_flush_left > 0) m_flush_left--;
    if (stalled && m_scount < (longint'(1) << CNT_W) - 1) m_scount++;
    m_run_len = stalled ? m_run_len + 1 : 0;
    if (m_run_len >= STALL_MAX) m_timeout = 1;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clock);
    #1;
    advance(prev);
    reset = s.rst_n; id_valid = s.valid; id_use_rs1 = s.use1; id_use_rs2 = s.use2;
    id_regwrite = s.regw; ex_branch_taken = s.br; wb_valid = s.wbv;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd; wb_rd = s.wbrd;
    predict(s);
    e.issue = m_issue; e.flush = m_flush; e.bubble = !m_issue;
    e.pcw = !(m_hazard && !m_flush); e.ifw = e.pcw;
    e.timeout = m_timeout; e.scount = m_scount;
    foreach (m_busy[i]) e.busy[i] = m_busy[i];
    exp_q.push_back(e);
    prev = s;
  endtask

  task automatic op(input bit valid, input bit [4:0] rs1, input bit use1, input bit [4:0] rs2,
                    input bit use2, input bit [4:0] rd, input bit regw, input bit br,
                    input bit wbv, input bit [4:0] wbrd, input bit rst_n = 1);
    stim_t s;
    s.rst_n = rst_n; s.valid = valid; s.rs1 = rs1; s.use1 = use1; s.rs2 = rs2; s.use2 = use2;
    s.rd = rd; s.regw = regw; s.br = br; s.wbv = wbv; s.wbrd = wbrd;
    drive(s);
  endtask

  task automatic idle(input int n, input bit rst_n = 1);
    for (int i = 0; i < n; i++) op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rst_n);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("issue",         issue,         e.issue);
        check("pc_write",      pc_write,      e.pcw);
        check("if_id_write",   if_id_write,   e.ifw);
        check("id_ex_bubble",  id_ex_bubble,  e.bubble);
        check("flush",         flush,         e.flush);
        check("busy_vec",      busy_vec,      e.busy);
        check("stall_count",   stall_count,   e.scount);
        check("stall_timeout", stall_timeout, e.timeout);
      end
    end
  end

  initial begin : driver
    stim_t s;
    reset = 0; id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0;
    ex_branch_taken = 0; wb_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; wb_rd = 0;
    prev = '{default: 0};
    m_flush_left = 0; m_scount = 0; m_run_len = 0; m_timeout = 0;
    foreach (m_busy[i]) m_busy[i] = 0;

    idle(2, 0);
    // Producer x5 then dependent consumer, released by writeback of x5.
    op(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    op(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    op(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    op(1, 5, 1, 0, 0, 6, 1, 0, 1, 5);
    op(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    op(1, 0, 0, 0, 0, 0, 0, 0, 1, 6);
    // Single-cycle branch in RUN followed by a steady instruction stream.
    op(1, 1, 1, 2, 1, 3, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) op(1, 1, 1, 2, 1, 3, 0, 0, 0, 0);
    // Same-edge set and clear of x7, then a write to x0.
    idle(1, 0);
    op(1, 0, 0, 0, 0, 7, 1, 0, 1, 7);
    op(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    op(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    // Branch during a stall, then reset in the middle of the flush.
    op(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    op(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
    op(1, 3, 1, 0, 0, 4, 1, 1, 0, 0);
    op(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0);
    op(1, 3, 1, 0, 0, 4, 1, 0, 0, 0);
    // Long hazard on x9 via rs2 to reach the timeout, then release.
    op(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    for (int i = 0; i < STALL_MAX + 2; i++) op(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    op(1, 0, 0, 9, 1, 0, 0, 0, 1, 9);
    op(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    idle(2);
    idle(1, 0);

    for (int i = 0; i < 500; i++) begin
      s.rst_n = ($urandom_range(0, 99) != 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.use1  = $urandom_range(0, 1);
      s.use2  = $urandom_range(0, 1);
      s.regw  = $urandom_range(0, 1);
      s.br    = ($urandom_range(0, 11) == 0);
      s.wbv   = $urandom_range(0, 1);
      s.rs1   = 5'($urandom_range(0, 7));
      s.rs2   = 5'($urandom_range(0, 7));
      s.rd    = 5'($urandom_range(0, 7));
      s.wbrd  = 5'($urandom_range(0, 7));
      drive(s);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters: FLUSH_CYCLES, 2, bubble cycles after a taken branch (1..7).
REQ-002 Parameters: STALL_MAX, 15, consecutive-stall limit before timeout.
REQ-003 Parameters: CNT_W, 16, stall_count width.
REQ-004 Ports: clock in 1 system clock; reset in 1 synchronous active-low reset.
REQ-005 Ports: id_valid in 1 decode slot holds an instruction; id_rs1, id_rs2, id_rd in 5 each, register indices.
REQ-006 Ports: id_use_rs1, id_use_rs2, id_regwrite in 1 each, instruction reads rs1, reads rs2, writes rd.
REQ-007 Ports: ex_branch_taken in 1 redirect from execute; wb_valid in 1 writeback occurring; wb_rd in 5 writeback destination.
REQ-008 Ports: issue out 1; pc_write out 1; if_id_write out 1; id_ex_bubble out 1; flush out 1.
REQ-009 Ports: busy_vec out 32 scoreboard; stall_count out CNT_W saturating perf counter; stall_timeout out 1 sticky error.

Function
REQ-010 The FSM SHALL have states RUN, STALL and FLUSH, encoded in 2 bits.
REQ-011 hazard SHALL be id_valid AND any of: (id_use_rs1, rs1!=0, busy[rs1]); (id_use_rs2, rs2!=0, busy[rs2]); (id_regwrite, rd!=0, busy[rd]) for WAW.
REQ-012 flush SHALL equal ex_branch_taken OR state==FLUSH, combinationally.
REQ-013 issue SHALL equal id_valid AND NOT hazard AND NOT flush.
REQ-014 pc_write and if_id_write SHALL be 0 when hazard AND NOT flush, and 1 otherwise; id_ex_bubble SHALL equal NOT issue.
REQ-015 RUN: ex_branch_taken goes to FLUSH with counter=FLUSH_CYCLES-1; otherwise hazard goes to STALL; otherwise stay.
REQ-016 STALL: ex_branch_taken goes to FLUSH; otherwise NOT hazard goes to RUN.
REQ-017 FLUSH: ex_branch_taken reloads counter to FLUSH_CYCLES-1; otherwise counter 0 goes to RUN, else counter decrements.
REQ-018 Scoreboard: at a clock edge with issue AND id_regwrite AND id_rd!=0, busy[id_rd] SHALL be set.
REQ-019 At a clock edge with wb_valid AND wb_rd!=0, busy[wb_rd] SHALL be cleared; set SHALL win when set and clear hit the same index.
REQ-020 busy_vec[0] SHALL always be 0; flush SHALL NOT clear busy bits.
REQ-021 stall_count SHALL increment each cycle hazard AND NOT flush, saturating at all-ones.
REQ-022 A consecutive-stall counter SHALL count cycles of hazard AND NOT flush and reset to 0 otherwise.
REQ-023 stall_timeout SHALL set when the consecutive-stall counter reaches STALL_MAX, and SHALL remain set until reset.

Reset
REQ-024 While reset==0 at a clock edge, state SHALL become RUN and the flush counter 0.
REQ-025 Reset SHALL also clear busy_vec, stall_count, the consecutive-stall counter and stall_timeout.
REQ-026 Reset SHALL override every simultaneous set, clear and branch event.
REQ-027 Combinational outputs SHALL follow REQ-012..014 during reset using the reset state: flush=ex_branch_taken, issue=id_valid AND NOT ex_branch_taken.

Configuration
REQ-028 Macro HAZARD_CTRL_BYPASS_EN: when defined, a source or rd matching wb_rd in the same cycle with wb_valid SHALL NOT count as busy for hazard.
REQ-029 Without HAZARD_CTRL_BYPASS_EN, the hazard check SHALL use only busy_vec, so the consumer stalls one extra cycle until the bit clears.

Verification
REQ-030 Issue x5 write, next cycle id_rs1=5 -> hazard: pc_write=0, id_ex_bubble=1, state STALL; wb x5 -> issue resumes (the same cycle with BYPASS_EN, the next cycle without).
REQ-031 ex_branch_taken one cycle in RUN, FLUSH_CYCLES=2 -> flush=1 for 3 cycles total, issue=0 throughout, RUN afterwards.
REQ-032 Same-edge issue x7 write and wb_rd=7 -> busy_vec[7]=1 afterwards; id_rd=0 with regwrite -> busy_vec stays 0.
REQ-033 Hold the hazard 15 cycles -> stall_timeout=1 and stays 1 after the hazard clears; stall_count=15.
REQ-034 Branch during STALL -> FLUSH and pc_write=1; reset=0 during FLUSH with busy bits set -> RUN, busy_vec=0, counters=0.
